// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALUOp codes, mux selects,
// state encodings and the control word. MULTI_CYCLE_CONTROL_BNE_EN adds the bne opcode.
package cpu_ctrl_pkg;

  localparam int CTRL_STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXE     = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXE     = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_BRANCH_NE = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_word_t;

  // Successor of DECODE; S_FETCH doubles as the "unsupported opcode" answer.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:                               nxt = S_MEM_ADR;
      OP_RTYPE:                                   nxt = S_R_EXE;
      OP_BEQ:                                     nxt = S_BRANCH;
      OP_J:                                       nxt = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: nxt = S_I_EXE;
`ifdef MULTI_CYCLE_CONTROL_BNE_EN
      OP_BNE:                                     nxt = S_BRANCH_NE;
`else
      OP_BNE:                                     nxt = S_FETCH;
`endif
      default:                                    nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control word decode; FETCH side effects gated by mem_ready.
// The BRANCH_NE word exists only with MULTI_CYCLE_CONTROL_BNE_EN defined.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [CTRL_STATE_W-1:0] state,
  input  logic [5:0]              op,
  input  logic                    mem_ready,
  output ctrl_word_t              cw
);

  // Control word per state; anything not listed stays 0.
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          cw.ir_write = 1'b1;
          cw.pc_write = 1'b1;
        end else begin
          cw.ir_write = 1'b0;
          cw.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMMSH2;
        cw.alu_op    = ALUOP_ADD;
        if (decode_next(op) == S_FETCH) begin
          cw.illegal_op = 1'b1;
        end else begin
          cw.illegal_op = 1'b0;
        end
      end
      S_MEM_ADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
      end
      S_R_EXE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_B;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_I_EXE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_IMM;
      end
      S_I_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b0;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
`ifdef MULTI_CYCLE_CONTROL_BNE_EN
      S_BRANCH_NE: begin
        cw.alu_src_a   = 1'b1;
        cw.alu_op      = ALUOP_SUB;
        cw.pc_write_ne = 1'b1;
        cw.pc_source   = PCSRC_ALUOUT;
      end
`endif
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state logic, output decode.
// Optional bne support via MULTI_CYCLE_CONTROL_BNE_EN; pc_write_ne stays 0 without it.
module multi_cycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_next_s;
  ctrl_word_t         cw_s;

  // State register; reset discards any partially executed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) state_next_s = S_DECODE;
        else           state_next_s = S_FETCH;
      end
      S_DECODE:  state_next_s = decode_next(op);
      S_MEM_ADR: begin
        if (op == OP_LW) state_next_s = S_MEM_RD;
        else             state_next_s = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) state_next_s = S_MEM_WB;
        else           state_next_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) state_next_s = S_FETCH;
        else           state_next_s = S_MEM_WR;
      end
      S_R_EXE: state_next_s = S_R_WB;
      S_I_EXE: state_next_s = S_I_WB;
      default: state_next_s = S_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state     (state_r),
    .op        (op),
    .mem_ready (mem_ready),
    .cw        (cw_s)
  );

  assign pc_write      = cw_s.pc_write;
  assign pc_write_cond = cw_s.pc_write_cond;
  assign pc_write_ne   = cw_s.pc_write_ne;
  assign i_or_d        = cw_s.i_or_d;
  assign mem_read      = cw_s.mem_read;
  assign mem_write     = cw_s.mem_write;
  assign ir_write      = cw_s.ir_write;
  assign mem_to_reg    = cw_s.mem_to_reg;
  assign reg_dst       = cw_s.reg_dst;
  assign reg_write     = cw_s.reg_write;
  assign alu_src_a     = cw_s.alu_src_a;
  assign alu_src_b     = cw_s.alu_src_b;
  assign alu_op        = cw_s.alu_op;
  assign pc_source     = cw_s.pc_source;
  assign illegal_op    = cw_s.illegal_op;

endmodule
